// File: rtl/pipelined_datapath.sv
// pipelined_datapath
//   Two-stage register-file + ALU datapath. Stage 1 accepts one instruction per
//   cycle over valid/ready and captures operands (with forwarding from the
//   instruction leaving EX). Stage 2 executes, writes back to the register file
//   and registers the result with its Z/N/C/V flags behind a valid/ready output.
//
//   Ports
//     clk        rising-edge clock for all state
//     reset      synchronous, active-high
//     in_valid   instr/instr_we are valid this cycle
//     in_ready   block can accept an instruction this cycle (combinational)
//     instr      {op[1:0], rd, rs1, rs2}, MSB first
//     instr_we   write the ALU result to rd at writeback
//     res_valid  alu_result/flags hold a new result
//     res_ready  consumer takes the result this cycle
//     alu_result registered ALU result
//     Z,N,C,V    registered flags of alu_result
module pipelined_datapath #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 16,
  localparam int AW     = $clog2(NREGS),
  localparam int IW     = 2 + 3 * AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     instr,
  input  logic              instr_we,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  // Instruction fields
  op_t           in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;

  assign in_op  = op_t'(instr[IW-1 -: 2]);
  assign in_rd  = instr[3*AW-1 -: AW];
  assign in_rs1 = instr[2*AW-1 -: AW];
  assign in_rs2 = instr[AW-1:0];

  logic [DATA_W-1:0] rf [NREGS];

  // EX stage registers
  logic              ex_valid;
  op_t               ex_op;
  logic [AW-1:0]     ex_rd;
  logic              ex_we;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;

  logic accept;
  logic adv;

  assign adv      = ex_valid & (~res_valid | res_ready);
  assign in_ready = ~ex_valid | adv;
  assign accept   = in_valid & in_ready;

  // ALU
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] y;
  logic              c_f;
  logic              v_f;

  assign sum  = {1'b0, ex_a} + {1'b0, ex_b};
  assign diff = {1'b0, ex_a} - {1'b0, ex_b};

  always_comb begin
    y   = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (ex_op)
      OP_ADD: begin
        y   = sum[MSB:0];
        c_f = sum[DATA_W];
        v_f = (ex_a[MSB] == ex_b[MSB]) & (y[MSB] != ex_a[MSB]);
      end
      OP_SUB: begin
        y   = diff[MSB:0];
        // carry means "no borrow", i.e. A >= B unsigned
        c_f = ~diff[DATA_W];
        v_f = (ex_a[MSB] != ex_b[MSB]) & (y[MSB] != ex_a[MSB]);
      end
      OP_AND: y = ex_a & ex_b;
      OP_OR:  y = ex_a | ex_b;
      default: y = '0;
    endcase
  end

  // Operand fetch with forwarding: the instruction leaving EX on this edge
  // writes the file on the same edge, so its result must bypass the read.
  logic              fwd_live;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign fwd_live = adv & ex_we;
  assign opa = (fwd_live && (ex_rd == in_rs1)) ? y : rf[in_rs1];
  assign opb = (fwd_live && (ex_rd == in_rs2)) ? y : rf[in_rs2];

  always_ff @(posedge clk) begin
    if (reset) begin
      rf         <= '{default: '0};
      ex_valid   <= 1'b0;
      ex_op      <= OP_ADD;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      res_valid  <= 1'b0;
      alu_result <= '0;
      Z          <= 1'b0;
      N          <= 1'b0;
      C          <= 1'b0;
      V          <= 1'b0;
    end else begin
      if (accept) begin
        ex_valid <= 1'b1;
        ex_op    <= in_op;
        ex_rd    <= in_rd;
        ex_we    <= instr_we;
        ex_a     <= opa;
        ex_b     <= opb;
      end else if (adv) begin
        ex_valid <= 1'b0;
      end

      if (adv) begin
        res_valid  <= 1'b1;
        alu_result <= y;
        Z          <= (y == '0);
        N          <= y[MSB];
        C          <= c_f;
        V          <= v_f;
        if (ex_we) begin
          rf[ex_rd] <= y;
        end
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
